// File: rtl/alu_dec.sv
// RV32I decode stage: turns one instruction into ALU controls, register fields and an immediate,
// held in a single valid/ready output register that feeds the execute stage.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef ALU_ADD
`define ALU_ADD  3'b000
`define ALU_SLL  3'b001
`define ALU_SLT  3'b010
`define ALU_SLTU 3'b011
`define ALU_XOR  3'b100
`define ALU_SRL  3'b101
`define ALU_OR   3'b110
`define ALU_AND  3'b111
`endif

module alu_dec (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    input  logic [31:0]        if_inst,
    input  logic [`DATA_W-1:0] if_pc,
    output logic               id_ready,
    input  logic               flush,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [2:0]         ex_s,
    output logic               ex_ext,
    output logic               ex_addcom,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic [`DATA_W-1:0] ex_imm,
    output logic               ex_use_imm,
    output logic               ex_a_pc,
    output logic               ex_we,
    output logic               ex_illegal,
    output logic [`DATA_W-1:0] ex_pc
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f3_add_sr;

    assign opcode    = if_inst[6:0];
    assign funct3    = if_inst[14:12];
    assign funct7    = if_inst[31:25];
    assign f3_add_sr = (funct3 == 3'b000) || (funct3 == 3'b101);

    logic [`DATA_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = `DATA_W'($signed(if_inst[31:20]));
    assign imm_s = `DATA_W'($signed({if_inst[31:25], if_inst[11:7]}));
    assign imm_b = `DATA_W'($signed({if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0}));
    assign imm_u = `DATA_W'($signed({if_inst[31:12], 12'b0}));
    assign imm_j = `DATA_W'($signed({if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21],
                                     1'b0}));

    logic [2:0]         d_s;
    logic               d_ext, d_addcom, d_use_imm, d_a_pc, d_we, d_ill;
    logic [4:0]         d_rs1, d_rs2, d_rd;
    logic [`DATA_W-1:0] d_imm;

    always_comb begin
        d_s       = `ALU_ADD;
        d_ext     = 1'b0;
        d_addcom  = 1'b0;
        d_use_imm = 1'b0;
        d_a_pc    = 1'b0;
        d_we      = 1'b0;
        d_ill     = 1'b0;
        d_imm     = '0;
        d_rs1     = if_inst[19:15];
        d_rs2     = if_inst[24:20];
        d_rd      = if_inst[11:7];
        case (opcode)
            OpcOp: begin
                d_s   = funct3;
                d_ext = f3_add_sr & if_inst[30];
                d_we  = 1'b1;
                d_ill = !((funct7 == 7'h00) || ((funct7 == 7'h20) && f3_add_sr));
            end
            OpcOpImm: begin
                d_s       = funct3;
                d_ext     = (funct3 == 3'b101) & if_inst[30];
                d_use_imm = 1'b1;
                d_imm     = imm_i;
                d_we      = 1'b1;
                if (funct3 == 3'b001) d_ill = (funct7 != 7'h00);
                if (funct3 == 3'b101) d_ill = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            OpcLoad, OpcJalr: begin
                d_addcom  = 1'b1;
                d_use_imm = 1'b1;
                d_imm     = imm_i;
                d_we      = 1'b1;
            end
            OpcStore: begin
                d_addcom  = 1'b1;
                d_use_imm = 1'b1;
                d_imm     = imm_s;
            end
            OpcLui: begin
                d_addcom  = 1'b1;
                d_use_imm = 1'b1;
                d_rs1     = 5'd0;
                d_imm     = imm_u;
                d_we      = 1'b1;
            end
            OpcAuipc, OpcJal: begin
                d_addcom  = 1'b1;
                d_use_imm = 1'b1;
                d_a_pc    = 1'b1;
                d_imm     = (opcode == OpcJal) ? imm_j : imm_u;
                d_we      = 1'b1;
            end
            OpcBranch: begin
                d_imm = imm_b;
                case (funct3)
                    3'b000, 3'b001: d_ext = 1'b1; // equality compares via subtract
                    3'b100, 3'b101: d_s = `ALU_SLT;
                    3'b110, 3'b111: d_s = `ALU_SLTU;
                    default:        d_ill = 1'b1;
                endcase
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_s       = `ALU_ADD;
            d_ext     = 1'b0;
            d_addcom  = 1'b0;
            d_use_imm = 1'b0;
            d_a_pc    = 1'b0;
            d_we      = 1'b0;
            d_imm     = '0;
        end
        if (d_rd == 5'd0) d_we = 1'b0;
    end

    logic load;

    assign id_ready = ~ex_valid | ex_ready;
    assign load     = if_valid & id_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_s       <= '0;
            ex_ext     <= 1'b0;
            ex_addcom  <= 1'b0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_imm     <= '0;
            ex_use_imm <= 1'b0;
            ex_a_pc    <= 1'b0;
            ex_we      <= 1'b0;
            ex_illegal <= 1'b0;
            ex_pc      <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (load) begin
            ex_valid   <= 1'b1;
            ex_s       <= d_s;
            ex_ext     <= d_ext;
            ex_addcom  <= d_addcom;
            ex_rs1     <= d_rs1;
            ex_rs2     <= d_rs2;
            ex_rd      <= d_rd;
            ex_imm     <= d_imm;
            ex_use_imm <= d_use_imm;
            ex_a_pc    <= d_a_pc;
            ex_we      <= d_we;
            ex_illegal <= d_ill;
            ex_pc      <= if_pc;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_dec.sv
// Bench for alu_dec: fixed decode vectors, hand-built stall/flush/reset sequences and a random
// stream checked against a spec-level decode and handshake model.
module tb_alu_dec;

    typedef struct packed {
        logic [2:0]  s;
        logic        ext;
        logic        addcom;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        a_pc;
        logic        we;
        logic        illegal;
    } dec_t;

    typedef struct {
        logic [31:0] inst;
        dec_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = '0;
    logic [31:0] if_pc = '0;
    logic        id_ready;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [2:0]  ex_s;
    logic        ex_ext, ex_addcom, ex_use_imm, ex_a_pc, ex_we, ex_illegal;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_imm, ex_pc;

    alu_dec dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_s(ex_s), .ex_ext(ex_ext), .ex_addcom(ex_addcom), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_use_imm(ex_use_imm), .ex_a_pc(ex_a_pc),
        .ex_we(ex_we), .ex_illegal(ex_illegal), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    dec_t dut_d;
    always_comb begin
        dut_d.s       = ex_s;
        dut_d.ext     = ex_ext;
        dut_d.addcom  = ex_addcom;
        dut_d.rs1     = ex_rs1;
        dut_d.rs2     = ex_rs2;
        dut_d.rd      = ex_rd;
        dut_d.imm     = ex_imm;
        dut_d.use_imm = ex_use_imm;
        dut_d.a_pc    = ex_a_pc;
        dut_d.we      = ex_we;
        dut_d.illegal = ex_illegal;
    end

    int tests = 0;
    int fails = 0;

    // Handshake model state
    bit          m_valid = 1'b0;
    dec_t        m_dec;
    logic [31:0] m_pc;

    function automatic dec_t mk(input int s, ext, addcom, rs1, rs2, rd, input logic [31:0] imm,
                                input int use_imm, a_pc, we, ill);
        dec_t d;
        d.s = 3'(s); d.ext = 1'(ext); d.addcom = 1'(addcom);
        d.rs1 = 5'(rs1); d.rs2 = 5'(rs2); d.rd = 5'(rd); d.imm = imm;
        d.use_imm = 1'(use_imm); d.a_pc = 1'(a_pc); d.we = 1'(we); d.illegal = 1'(ill);
        return d;
    endfunction

    // Reference decode from the instruction-set rules, using integer arithmetic for immediates
    function automatic dec_t model(input logic [31:0] i);
        dec_t d;
        int   si;
        int   f3, f7;
        bit   legal;
        int   imm_i, imm_s, imm_b, imm_u, imm_j;
        si = int'(i);
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        imm_i = si >>> 20;
        imm_s = ((si >>> 25) * 32) + int'(i[11:7]);
        imm_u = si - int'(i[11:0]);
        imm_b = ((si >>> 31) * 4096) + int'(i[7]) * 2048 + int'(i[30:25]) * 32
              + int'(i[11:8]) * 2;
        imm_j = ((si >>> 31) * 1048576) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
              + int'(i[30:21]) * 2;
        d = '0;
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.rd  = i[11:7];
        legal = 1'b1;
        case (i[6:0])
            7'h33: begin
                legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                d.s = 3'(f3); d.ext = (f3 == 0 || f3 == 5) && i[30]; d.we = 1'b1;
            end
            7'h13: begin
                if (f3 == 1) legal = (f7 == 0);
                if (f3 == 5) legal = (f7 == 0 || f7 == 32);
                d.s = 3'(f3); d.ext = (f3 == 5) && i[30]; d.use_imm = 1'b1;
                d.imm = 32'(imm_i); d.we = 1'b1;
            end
            7'h03, 7'h67: begin
                d.addcom = 1'b1; d.use_imm = 1'b1; d.imm = 32'(imm_i); d.we = 1'b1;
            end
            7'h23: begin
                d.addcom = 1'b1; d.use_imm = 1'b1; d.imm = 32'(imm_s);
            end
            7'h37: begin
                d.addcom = 1'b1; d.use_imm = 1'b1; d.rs1 = 5'd0; d.imm = 32'(imm_u); d.we = 1'b1;
            end
            7'h17, 7'h6F: begin
                d.addcom = 1'b1; d.use_imm = 1'b1; d.a_pc = 1'b1; d.we = 1'b1;
                d.imm = (i[6:0] == 7'h6F) ? 32'(imm_j) : 32'(imm_u);
            end
            7'h63: begin
                d.imm = 32'(imm_b);
                if (f3 == 2 || f3 == 3) legal = 1'b0;
                else if (f3 < 2) d.ext = 1'b1;
                else d.s = (f3 < 6) ? 3'd2 : 3'd3;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            d.s = 3'd0; d.ext = 1'b0; d.addcom = 1'b0; d.use_imm = 1'b0; d.a_pc = 1'b0;
            d.we = 1'b0; d.imm = '0; d.illegal = 1'b1;
        end
        if (d.rd == 5'd0) d.we = 1'b0;
        return d;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dec(input string name, input dec_t act, input dec_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got s=%0d ext=%b ac=%b rs1=%0d rs2=%0d rd=%0d imm=%h ui=%b apc=%b we=%b ill=%b, expected s=%0d ext=%b ac=%b rs1=%0d rs2=%0d rd=%0d imm=%h ui=%b apc=%b we=%b ill=%b",
                     name, act.s, act.ext, act.addcom, act.rs1, act.rs2, act.rd, act.imm,
                     act.use_imm, act.a_pc, act.we, act.illegal, exp.s, exp.ext, exp.addcom,
                     exp.rs1, exp.rs2, exp.rd, exp.imm, exp.use_imm, exp.a_pc, exp.we,
                     exp.illegal);
        end
    endtask

    // Called at posedge+1 with inputs already set; checks id_ready, clocks, checks outputs.
    task automatic cycle(input string name);
        bit exp_ready;
        #1;
        exp_ready = !m_valid || ex_ready;
        chk_bit({name, ".id_ready"}, id_ready, exp_ready);
        @(posedge clk);
        if (flush) m_valid = 1'b0;
        else if (if_valid && exp_ready) begin
            m_valid = 1'b1;
            m_dec   = model(if_inst);
            m_pc    = if_pc;
        end else if (ex_ready) m_valid = 1'b0;
        #1;
        chk_bit({name, ".ex_valid"}, ex_valid, m_valid);
        if (m_valid) begin
            chk_dec({name, ".dec"}, dut_d, m_dec);
            chk_word({name, ".pc"}, ex_pc, m_pc);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        if_valid = v; if_inst = inst; if_pc = pc; ex_ready = rdy; flush = fl;
    endtask

    localparam logic [6:0] Opcodes [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h37, 7'h17,
                                          7'h6F, 7'h63, 7'h33, 7'h13};

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h002081B3, mk(0, 0, 0, 1, 2, 3, 32'h0, 0, 0, 1, 0)};          // ADD
        vecs[1] = '{32'h402081B3, mk(0, 1, 0, 1, 2, 3, 32'h0, 0, 0, 1, 0)};          // SUB
        vecs[2] = '{32'h40435293, mk(5, 1, 0, 6, 4, 5, 32'h404, 1, 0, 1, 0)};        // SRAI
        vecs[3] = '{32'hFFC12083, mk(0, 0, 1, 2, 28, 1, 32'hFFFFFFFC, 1, 0, 1, 0)};  // LW
        vecs[4] = '{32'h00000000, mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1)};          // illegal
        vecs[5] = '{32'h123452B7, mk(0, 0, 1, 0, 3, 5, 32'h12345000, 1, 0, 1, 0)};   // LUI
        vecs[6] = '{32'h00209463, mk(0, 1, 0, 1, 2, 8, 32'h8, 0, 0, 0, 0)};          // BNE +8
        vecs[7] = '{32'h00001017, mk(0, 0, 1, 0, 0, 0, 32'h1000, 1, 1, 0, 0)};       // AUIPC x0
        vecs[8] = '{32'h802081B3, mk(0, 0, 0, 1, 2, 3, 32'h0, 0, 0, 0, 1)};          // bad funct7

        // Reset state
        #12;
        chk_bit("reset.ex_valid", ex_valid, 1'b0);
        chk_bit("reset.id_ready", id_ready, 1'b1);
        chk_dec("reset.dec", dut_d, '0);
        chk_word("reset.pc", ex_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed vectors under continuous flow
        foreach (vecs[k]) begin
            drive(1'b1, vecs[k].inst, 32'h1000 + 32'(k * 4), 1'b1, 1'b0);
            cycle($sformatf("vec%0d", k));
            chk_dec($sformatf("vec%0d.table", k), dut_d, vecs[k].exp);
            chk_word($sformatf("vec%0d.pc_table", k), ex_pc, 32'h1000 + 32'(k * 4));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cycle("drain");

        // Back-pressure: ADD held for three cycles while SUB waits
        drive(1'b1, vecs[0].inst, 32'h200, 1'b1, 1'b0);
        cycle("stall.load");
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, vecs[1].inst, 32'h204, 1'b0, 1'b0);
            cycle($sformatf("stall%0d", c));
            chk_bit("stall.id_ready_low", id_ready, 1'b0);
            chk_dec("stall.hold", dut_d, vecs[0].exp);
            chk_word("stall.hold_pc", ex_pc, 32'h200);
        end
        drive(1'b1, vecs[1].inst, 32'h204, 1'b1, 1'b0);
        cycle("stall.release");
        chk_bit("stall.no_bubble", ex_valid, 1'b1);
        chk_dec("stall.next", dut_d, vecs[1].exp);

        // Flush beats a simultaneous load and consume
        drive(1'b1, vecs[3].inst, 32'h300, 1'b1, 1'b1);
        cycle("flush");
        chk_bit("flush.ex_valid", ex_valid, 1'b0);
        drive(1'b0, vecs[3].inst, 32'h300, 1'b1, 1'b0);
        cycle("flush.dropped");
        chk_bit("flush.stays_empty", ex_valid, 1'b0);
        drive(1'b1, 32'h0, 32'h304, 1'b1, 1'b0);
        cycle("flush.illegal");
        chk_bit("illegal.valid", ex_valid, 1'b1);
        chk_bit("illegal.flag", ex_illegal, 1'b1);
        chk_bit("illegal.we", ex_we, 1'b0);

        // Asynchronous reset between edges while holding a valid instruction
        drive(1'b1, vecs[2].inst, 32'h400, 1'b0, 1'b0);
        cycle("areset.load");
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bit("areset.ex_valid", ex_valid, 1'b0);
        chk_dec("areset.dec", dut_d, '0);
        chk_word("areset.pc", ex_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0;
        #1;
        chk_bit("areset.id_ready", id_ready, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b1, vecs[5].inst, 32'h500, 1'b1, 1'b0);
        cycle("areset.first");
        chk_dec("areset.first_table", dut_d, vecs[5].exp);

        // Random stream
        for (int n = 0; n < 600; n++) begin
            logic [31:0] inst;
            inst = $urandom;
            if ($urandom_range(0, 7) != 0) inst[6:0] = Opcodes[$urandom_range(0, 10)];
            if ($urandom_range(0, 3) != 0) inst[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            drive($urandom_range(0, 3) != 0, inst, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            cycle($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
